// File: rtl/uart_pkt_framer.sv
// Buffers UART bytes in a circular RAM and frames them into UDP packets,
// closed on MAX_LEN bytes or after IDLE_CYC quiet cycles, drained when tx_busy is low.
module uart_pkt_framer #(
  parameter int MAX_LEN  = 256,
  parameter int DEPTH    = 512,
  parameter int IDLE_CYC = 8680
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx_done,
  input  logic [7:0]  uart_rx_data,
  input  logic        tx_busy,
  output logic        rec_en,
  output logic [7:0]  rec_data,
  output logic        tx_start_en,
  output logic [15:0] tx_byte_num,
  output logic [15:0] drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(IDLE_CYC + 1);

  typedef enum logic [1:0] {D_IDLE, D_WAIT, D_READ, D_START} dstate_t;

  logic [7:0]    ram [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] level, ucnt, rd_left;
  logic [TW-1:0] timer;
  dstate_t       state;

  logic          wr_acc, wr_drop, rd_issue, close;
  logic [CW-1:0] pkt_len, ucnt_sub;

  always_comb begin
    wr_acc   = uart_rx_done && (level != CW'(DEPTH));
    wr_drop  = uart_rx_done && (level == CW'(DEPTH));
    rd_issue = (state == D_READ) && (rd_left != '0);
    close    = (state == D_IDLE) &&
               ((ucnt >= CW'(MAX_LEN)) || ((ucnt != '0) && (timer == TW'(IDLE_CYC))));
    pkt_len  = (ucnt >= CW'(MAX_LEN)) ? CW'(MAX_LEN) : ucnt;
    ucnt_sub = close ? pkt_len : '0;
  end

  always_ff @(posedge clk) begin
    if (wr_acc) ram[wptr] <= uart_rx_data;
  end

  // RAM read register doubles as the rec_data output so it can be reset to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec_data <= '0;
    end else if (rd_issue) begin
      rec_data <= ram[rptr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr        <= '0;
      rptr        <= '0;
      level       <= '0;
      ucnt        <= '0;
      timer       <= '0;
      rd_left     <= '0;
      drop_cnt    <= '0;
      tx_byte_num <= '0;
      rec_en      <= 1'b0;
      tx_start_en <= 1'b0;
      state       <= D_IDLE;
    end else begin
      rec_en      <= rd_issue;
      tx_start_en <= 1'b0;

      if (wr_acc) wptr <= wptr + AW'(1);
      if (rd_issue) rptr <= rptr + AW'(1);
      level <= level + CW'(wr_acc) - CW'(rd_issue);
      // A byte written in the closing cycle lands in the remainder.
      ucnt  <= ucnt - ucnt_sub + CW'(wr_acc);

      if (wr_drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;

      if (uart_rx_done || (ucnt == '0)) timer <= '0;
      else if (timer != TW'(IDLE_CYC)) timer <= timer + TW'(1);

      case (state)
        D_IDLE: begin
          if (close) begin
            tx_byte_num <= 16'(pkt_len);
            rd_left     <= pkt_len;
            state       <= D_WAIT;
          end
        end
        D_WAIT: begin
          if (!tx_busy) state <= D_READ;
        end
        D_READ: begin
          // One extra cycle after the last read lets its rec_en leave before D_START.
          if (rd_left != '0) begin
            rd_left <= rd_left - CW'(1);
          end else begin
            tx_start_en <= 1'b1;
            state       <= D_START;
          end
        end
        D_START: begin
          state <= D_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_pkt_framer.md
UART_PKT_FRAMER -- requirements
Module: uart_pkt_framer

Interface
REQ-001 Parameter MAX_LEN, default 256, maximum payload bytes per UDP packet (1..1024).
REQ-002 Parameter DEPTH, default 512, byte-buffer depth; power of two, at least MAX_LEN.
REQ-003 Parameter IDLE_CYC, default 8680, idle clk cycles that close a partial packet (two 115200-baud characters at 50 MHz).
REQ-004 clk  input  1  system clock, 50 MHz; the block has this one clock only.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 uart_rx_done  input  1  one-cycle strobe, byte valid on uart_rx_data.
REQ-007 uart_rx_data  input  8  received UART byte.
REQ-008 tx_busy  input  1  UDP transmitter busy; drainer shall not start a packet readout while high.
REQ-009 rec_en  output  1  one-cycle strobe per payload byte to the UDP TX FIFO.
REQ-010 rec_data  output  8  payload byte, valid while rec_en is high.
REQ-011 tx_start_en  output  1  one-cycle strobe, start UDP transmission.
REQ-012 tx_byte_num  output  16  byte count of the packet, stable from the first rec_en until the next packet close.
REQ-013 drop_cnt  output  16  count of bytes dropped on buffer overflow; saturates at 0xFFFF.

Function
REQ-014 Buffer: circular RAM of DEPTH bytes with write pointer, read pointer and level, with a synchronous one-cycle read.
REQ-015 Write: on uart_rx_done with level<DEPTH, store the byte, increment wptr (mod DEPTH) and increment ucnt, the uncommitted byte count.
REQ-016 Overflow: on uart_rx_done with level==DEPTH (registered value, a same-cycle read frees no space), discard the byte and increment drop_cnt, saturating.
REQ-017 Idle timer: clear on uart_rx_done or when ucnt==0, otherwise increment, saturating at IDLE_CYC.
REQ-018 Close condition: drainer in D_IDLE and (ucnt>=MAX_LEN, or ucnt>0 with timer==IDLE_CYC).
REQ-019 Close action at cycle T: pkt_len = min(ucnt, MAX_LEN); ucnt -= pkt_len; tx_byte_num <= pkt_len; drainer -> D_WAIT at T+1.
REQ-020 Simultaneous close and write: close uses the registered ucnt, and the byte written in the same cycle joins the remainder (ucnt = old - pkt_len + 1).
REQ-021 While the drainer is not in D_IDLE, no close occurs; writes and ucnt accumulation continue, and a pending close fires on the first D_IDLE cycle.
REQ-022 Drainer FSM states: D_IDLE, D_WAIT, D_READ, D_START.
REQ-023 D_WAIT: exit to D_READ on the first cycle with tx_busy==0, otherwise hold.
REQ-024 D_READ: issue one RAM read per cycle for pkt_len cycles, advancing rptr (mod DEPTH) and decrementing level; then go to D_START.
REQ-025 rec_en/rec_data: registered, asserted exactly one cycle after each read issue; exactly pkt_len back-to-back strobes, in write order.
REQ-026 D_START: entered the cycle after the last rec_en; assert tx_start_en for one cycle, then go to D_IDLE.
REQ-027 Latency: with tx_busy low, close at T gives rec_en on cycles T+3..T+2+pkt_len and tx_start_en at T+3+pkt_len.
REQ-028 tx_busy rising during D_READ or D_START has no effect; the current packet completes.
REQ-029 Level: +1 on an accepted write, -1 on a read issue, both in the same cycle net 0; never exceeds DEPTH and never underflows.
REQ-030 Wrap-around: pointers wrap mod DEPTH, and a packet spanning the wrap is read contiguously with no gap or reorder.

Reset
REQ-031 rst_n low shall asynchronously clear pointers, level, ucnt, timer, drop_cnt and tx_byte_num, and set the FSM to D_IDLE.
REQ-032 Reset shall drive rec_en=0, rec_data=0x00 and tx_start_en=0.
REQ-033 Reset mid-packet discards all buffered bytes, and no strobe shall be issued for them after release.
REQ-034 RAM contents need no reset.

Verification
REQ-035 Five bytes 0x11..0x15, 4340 cycles apart, tx_busy=0 -> IDLE_CYC after the last byte: 5 rec_en with 0x11..0x15, then tx_start_en, with tx_byte_num=5.
REQ-036 300 bytes back-to-back with MAX_LEN=256 -> first packet of 256 bytes closes at the 256th byte; second packet of 44 bytes after the idle timeout; data continuous across both packets.
REQ-037 tx_busy held high 20000 cycles after a close -> no rec_en until tx_busy falls; bytes arriving meanwhile are buffered and form the next packet.
REQ-038 With DEPTH=512 and tx_busy high, write 515 bytes -> drop_cnt=3; after tx_busy falls, 512 bytes are delivered with none corrupted.
REQ-039 Write aligned so a packet spans pointer wrap (wptr starts at 500, 20 bytes) -> 20 rec_en in order, tx_byte_num=20.
REQ-040 rst_n pulsed low during D_READ of a 100-byte packet -> all outputs zero immediately; no tx_start_en afterwards; a new 3-byte stream yields tx_byte_num=3.
